// File: rtl/slave_split_ctrl.sv
// slave_split_ctrl: split-transaction controller for a bus slave.
// A slow backing store causes the slave to split the owning master off the
// bus, then resume it once the data is ready and that master is regranted.
// Optional feature macro: SPLIT_TIMEOUT_EN adds a split watchdog that
// abandons a split after TIMEOUT_CYCLES and pulses split_err.
module slave_split_ctrl #(
  parameter int unsigned SPLIT_THRESHOLD = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic       MASTER_CLK,
  input  logic       MASTER_RST_N,
  input  logic       slave_sel_me,
  input  logic [1:0] bus_grant,
  input  logic       tx_start,
  input  logic       tx_done,
  input  logic       mem_ready,
  output logic       SPLIT_EN,
  output logic [1:0] split_owner,
  output logic       resume,
  output logic       slave_ready,
  output logic [7:0] split_count,
  output logic       split_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    SPLIT,
    RESUME_WAIT,
    ACTIVE
  } state_t;

  // Last wait count before a split is issued, sized to the wait counter.
  localparam logic [7:0] ThrLast = 8'(SPLIT_THRESHOLD - 1);

  // Reject parameter values outside their legal ranges at elaboration.
  if (SPLIT_THRESHOLD < 1 || SPLIT_THRESHOLD > 255) begin : g_bad_threshold
    $error("slave_split_ctrl: SPLIT_THRESHOLD must be 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("slave_split_ctrl: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t     state_q;
  logic       split_en_q;
  logic [1:0] split_owner_q;
  logic       resume_q;
  logic       slave_ready_q;
  logic [7:0] split_count_q;
  logic [7:0] split_count_d;
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;
  logic       grant_valid;

  assign grant_valid   = (bus_grant == 2'b01) || (bus_grant == 2'b10);
  assign wait_cnt_d    = wait_cnt_q + 8'd1;
  assign split_count_d = (split_count_q == 8'hFF) ? 8'hFF : split_count_q + 8'd1;

`ifdef SPLIT_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] watchdog_q;
  logic [15:0] watchdog_d;
  logic        split_err_q;

  assign watchdog_d = watchdog_q + 16'd1;
  assign split_err  = split_err_q;
`else
  assign split_err  = 1'b0;
`endif

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge MASTER_CLK or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      state_q       <= IDLE;
      split_en_q    <= 1'b0;
      split_owner_q <= 2'b00;
      resume_q      <= 1'b0;
      slave_ready_q <= 1'b0;
      split_count_q <= 8'd0;
      wait_cnt_q    <= 8'd0;
`ifdef SPLIT_TIMEOUT_EN
      watchdog_q    <= 16'd0;
      split_err_q   <= 1'b0;
`endif
    end else begin
      resume_q <= 1'b0;
`ifdef SPLIT_TIMEOUT_EN
      split_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (tx_start && slave_sel_me && grant_valid) begin
            split_owner_q <= bus_grant;
            wait_cnt_q    <= 8'd0;
            if (mem_ready) begin
              state_q       <= ACTIVE;
              slave_ready_q <= 1'b1;
            end else begin
              state_q <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_ready) begin
            state_q       <= ACTIVE;
            slave_ready_q <= 1'b1;
          end else if (wait_cnt_q == ThrLast) begin
            state_q       <= SPLIT;
            split_en_q    <= 1'b1;
            split_count_q <= split_count_d;
`ifdef SPLIT_TIMEOUT_EN
            watchdog_q    <= 16'd0;
`endif
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        SPLIT: begin
          if (mem_ready) begin
            state_q    <= RESUME_WAIT;
            split_en_q <= 1'b0;
            resume_q   <= 1'b1;
`ifdef SPLIT_TIMEOUT_EN
          end else if (watchdog_q == ToLast) begin
            state_q       <= IDLE;
            split_en_q    <= 1'b0;
            split_err_q   <= 1'b1;
            split_owner_q <= 2'b00;
          end else begin
            watchdog_q <= watchdog_d;
`endif
          end
        end
        RESUME_WAIT: begin
          if (slave_sel_me && (bus_grant == split_owner_q)) begin
            state_q       <= ACTIVE;
            slave_ready_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (tx_done) begin
            state_q       <= IDLE;
            slave_ready_q <= 1'b0;
            split_owner_q <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SPLIT_EN    = split_en_q;
  assign split_owner = split_owner_q;
  assign resume      = resume_q;
  assign slave_ready = slave_ready_q;
  assign split_count = split_count_q;

endmodule
